// File: rtl/hilo_pipe.sv
// HI/LO write-back path: EX/MEM and MEM/WB staging plus the architectural HI/LO pair.
// Optional macro HILO_WCOUNT_EN adds a committed HI/LO write counter on hilo_wcnt_o.
module hilo_pipe (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_whilo_i,
   input  logic [31:0] ex_hi_i,
   input  logic [31:0] ex_lo_i,
   input  logic [4:0]  ex_wd_i,
   input  logic        ex_wreg_i,
   input  logic [31:0] ex_wdata_i,
   input  logic        stall_mem_i,
   input  logic        stall_wb_i,
   input  logic        flush_i,
   output logic        mem_whilo_o,
   output logic [31:0] mem_hi_o,
   output logic [31:0] mem_lo_o,
   output logic [4:0]  mem_wd_o,
   output logic        mem_wreg_o,
   output logic [31:0] mem_wdata_o,
   output logic        wb_whilo_o,
   output logic [31:0] wb_hi_o,
   output logic [31:0] wb_lo_o,
   output logic [4:0]  wb_wd_o,
   output logic        wb_wreg_o,
   output logic [31:0] wb_wdata_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic [31:0] hilo_wcnt_o
);

   typedef struct packed {
      logic        whilo;
      logic [31:0] hi;
      logic [31:0] lo;
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] wdata;
   } stage_t;

   stage_t      ex_s;
   stage_t      mem_d, mem_q;
   stage_t      wb_d, wb_q;
   logic [31:0] hi_q, lo_q;

   always_comb begin
      ex_s.whilo = ex_whilo_i;
      ex_s.hi    = ex_hi_i;
      ex_s.lo    = ex_lo_i;
      ex_s.wd    = ex_wd_i;
      ex_s.wreg  = ex_wreg_i;
      ex_s.wdata = ex_wdata_i;
   end

   // stall_wb_i alone is illegal; it falls into the hold-both branch.
   always_comb begin
      mem_d = mem_q;
      wb_d  = wb_q;
      if (flush_i) begin
         mem_d = '0;
         wb_d  = '0;
      end else if (stall_wb_i) begin
         mem_d = mem_q;
         wb_d  = wb_q;
      end else if (stall_mem_i) begin
         wb_d  = '0;
      end else begin
         mem_d = ex_s;
         wb_d  = mem_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         mem_q <= mem_d;
         wb_q  <= wb_d;
      end
   end

   // The WB instruction is already committed, so flush and stalls never block this.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (wb_q.whilo) begin
         hi_q <= wb_q.hi;
         lo_q <= wb_q.lo;
      end
   end

`ifdef HILO_WCOUNT_EN
   logic [31:0] wcnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wcnt_q <= '0;
      end else if (wb_q.whilo) begin
         wcnt_q <= wcnt_q + 32'd1;
      end
   end

   assign hilo_wcnt_o = wcnt_q;
`else
   assign hilo_wcnt_o = '0;
`endif

   assign mem_whilo_o = mem_q.whilo;
   assign mem_hi_o    = mem_q.hi;
   assign mem_lo_o    = mem_q.lo;
   assign mem_wd_o    = mem_q.wd;
   assign mem_wreg_o  = mem_q.wreg;
   assign mem_wdata_o = mem_q.wdata;
   assign wb_whilo_o  = wb_q.whilo;
   assign wb_hi_o     = wb_q.hi;
   assign wb_lo_o     = wb_q.lo;
   assign wb_wd_o     = wb_q.wd;
   assign wb_wreg_o   = wb_q.wreg;
   assign wb_wdata_o  = wb_q.wdata;
   assign hi_o        = hi_q;
   assign lo_o        = lo_q;

endmodule
